frame_buffer_arbiter: RTL and testbench
=======================================

Name: frame_buffer_arbiter

Overview:
- Owns the single-port 640x480x8 frame buffer RAM (one access per Clk).
- Shares that port between three requesters: the display fetch path (reads), the drawing engine (writes), and an internal screen-clear engine.
- Sits between the frame displayer / drawing logic and the frame buffer. All RAM control outputs are registered.

Parameters:
- ADDR_W, 19, frame buffer address width.
- DATA_W, 8, pixel word width (palette index).
- FRAME_WORDS, 307200, number of valid addresses (640*480); valid addresses are 0..FRAME_WORDS-1.

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_rd_req  in  1  display read request, single cycle, no handshake
- disp_rd_addr  in  ADDR_W  display read address
- disp_rd_valid  out  1  display read data valid
- disp_rd_data  out  DATA_W  display read data
- draw_wr_req  in  1  draw write request, held until ack
- draw_wr_addr  in  ADDR_W  draw write address
- draw_wr_data  in  DATA_W  draw write data
- draw_wr_ack  out  1  one-cycle write acknowledge
- clear_start  in  1  start full-screen fill
- clear_color  in  DATA_W  fill value, sampled on accepted start
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse when the clear finishes
- mem_addr  out  ADDR_W  RAM address, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_we  out  1  RAM write enable, registered
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented

Behaviour:
- Reset values: every output is 0, the clear FSM is in IDLE, the clear counter is 0, and the read pipeline is empty.
- Reset mid-clear aborts the clear with no clear_done pulse. Reset during a pending read drops it, so disp_rd_valid stays 0.
- Grant in cycle t uses fixed priority: display read > clear write > draw write. At most one grant per cycle. A loser is not granted in cycle t and is re-evaluated in t+1.
- Display read, granted in t:
  - mem_addr = disp_rd_addr and mem_we = 0 in t+1.
  - disp_rd_valid = 1 in t+2, with disp_rd_data = mem_rdata.
  - Fixed latency of 2; reads are never dropped or stalled.
- Display read with disp_rd_addr >= FRAME_WORDS: no RAM access, and the slot is free for other requesters. disp_rd_valid still pulses in t+2 with disp_rd_data = 0.
- Draw write, granted in t:
  - mem_we = 1, mem_addr = draw_wr_addr, mem_wdata = draw_wr_data in t+1.
  - draw_wr_ack = 1 in t+1.
  - The requester keeps req, addr and data stable until it sees ack, and may drop req in the cycle after ack.
  - The arbiter does not grant a draw in any cycle where draw_wr_ack is high, which prevents double writes. Peak draw rate is 1 per 2 cycles.
- Draw write with draw_wr_addr >= FRAME_WORDS: acked at the normal time but mem_we stays 0 (silently dropped).
- Draw requests are never granted while clear_busy = 1 (they stall until the clear ends).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE to CLEAR on clear_start: latch clear_color, counter = 0, clear_busy = 1 from the next cycle.
  - CLEAR, each cycle with no display grant: write the latched color to address counter (same t+1 timing as draws), then counter++.
  - CLEAR to DONE in the cycle the write of address FRAME_WORDS-1 is granted.
  - DONE: clear_done = 1 for exactly 1 cycle, clear_busy = 0, then return to IDLE.
  - clear_start is ignored while in CLEAR or DONE. The counter never exceeds FRAME_WORDS-1 (no wrap).
- Uncontended clear duration is FRAME_WORDS grant cycles. Every display grant adds one cycle.
- In idle cycles (no grant), mem_we = 0 and mem_addr/mem_wdata hold their previous values.

Test Plan:
- Reset, then disp_rd_req with addr 0x00010 on idle RAM preloaded with 0x5A -> mem_addr = 0x00010, mem_we = 0 at t+1; disp_rd_valid = 1 and disp_rd_data = 0x5A at t+2.
- draw_wr_req (addr 0x1234, data 0x3C) held, with disp_rd_req asserted in the same cycle -> read granted first. Write lands one cycle later: mem_we = 1 with 0x1234/0x3C and draw_wr_ack = 1. Exactly one write occurs even though req is still high in the ack cycle.
- draw_wr_req to addr 307200 -> draw_wr_ack pulses, mem_we never asserts. disp_rd_req to addr 400000 -> valid at t+2 with data 0x00, no RAM access.
- clear_start with color 0x07 and disp_rd_req on every other cycle:
  - Every address 0..307199 is written with 0x07 exactly once.
  - The clear takes 307200 + (number of display grants) cycles.
  - clear_done pulses once; a held draw_wr_req is acked only after clear_busy falls; a second clear_start mid-clear is ignored.
- reset asserted at counter = 1000 mid-clear -> all outputs 0 next cycle, no clear_done. A fresh clear_start then restarts from address 0.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer arbiter: display reads > screen clear > draw writes.
// All RAM control outputs are registered; display read data returns two cycles after grant.
module frame_buffer_arbiter #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_WORDS = 307200
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              disp_rd_req,
  input  logic [ADDR_W-1:0] disp_rd_addr,
  output logic              disp_rd_valid,
  output logic [DATA_W-1:0] disp_rd_data,
  input  logic              draw_wr_req,
  input  logic [ADDR_W-1:0] draw_wr_addr,
  input  logic [DATA_W-1:0] draw_wr_data,
  output logic              draw_wr_ack,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ADDR_W:0]   FRAME_LIM = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              ack_q, ack_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_pend_oob_q, rd_pend_oob_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_oob_q, rd_oob_d;

  logic rd_in_range, wr_in_range;
  logic rd_grant, clr_grant, draw_grant;

  always_comb begin
    rd_in_range = {1'b0, disp_rd_addr} < FRAME_LIM;
    wr_in_range = {1'b0, draw_wr_addr} < FRAME_LIM;

    // Out-of-range reads do not occupy the RAM slot; ack_q blocks a repeat grant of a held draw
    rd_grant   = disp_rd_req && rd_in_range;
    clr_grant  = !rd_grant && (state_q == ST_CLEAR);
    draw_grant = !rd_grant && (state_q != ST_CLEAR) && draw_wr_req && !ack_q;

    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (rd_grant) begin
      mem_addr_d = disp_rd_addr;
    end else if (clr_grant) begin
      mem_addr_d  = cnt_q;
      mem_wdata_d = color_q;
      mem_we_d    = 1'b1;
    end else if (draw_grant && wr_in_range) begin
      mem_addr_d  = draw_wr_addr;
      mem_wdata_d = draw_wr_data;
      mem_we_d    = 1'b1;
    end

    ack_d         = draw_grant;
    rd_pend_d     = disp_rd_req;
    rd_pend_oob_d = !rd_in_range;
    rd_valid_d    = rd_pend_q;
    rd_oob_d      = rd_pend_oob_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          color_d = clear_color;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_grant) begin
          if (cnt_q == LAST_ADDR) state_d = ST_DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      color_q       <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      ack_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_pend_oob_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_oob_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      color_q       <= color_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      ack_q         <= ack_d;
      rd_pend_q     <= rd_pend_d;
      rd_pend_oob_q <= rd_pend_oob_d;
      rd_valid_q    <= rd_valid_d;
      rd_oob_q      <= rd_oob_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign draw_wr_ack   = ack_q;
  assign clear_busy    = (state_q == ST_CLEAR);
  assign clear_done    = (state_q == ST_DONE);
  assign disp_rd_valid = rd_valid_q;
  assign disp_rd_data  = (rd_valid_q && !rd_oob_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a synchronous RAM model and write monitor.
// Uses a reduced frame size so a full clear stays short.
module tb_frame_buffer_arbiter;

  localparam int unsigned FW = 8192;

  logic        Clk;
  logic        reset;
  logic        disp_rd_req;
  logic [18:0] disp_rd_addr;
  logic        disp_rd_valid;
  logic [7:0]  disp_rd_data;
  logic        draw_wr_req;
  logic [18:0] draw_wr_addr;
  logic [7:0]  draw_wr_data;
  logic        draw_wr_ack;
  logic        clear_start;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0] ram  [0:FW-1];
  logic [7:0] wcnt [0:FW-1];
  logic [7:0] rdata_q;
  logic       mon_fill, mon_clr;
  int         wr_total = 0;
  int         tests = 0;
  int         failures = 0;

  frame_buffer_arbiter #(.ADDR_W(19), .DATA_W(8), .FRAME_WORDS(FW)) dut (
    .Clk(Clk), .reset(reset),
    .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
    .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
    .draw_wr_req(draw_wr_req), .draw_wr_addr(draw_wr_addr),
    .draw_wr_data(draw_wr_data), .draw_wr_ack(draw_wr_ack),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign mem_rdata = rdata_q;

  always @(posedge Clk) begin
    if (mon_fill) for (int i = 0; i < FW; i++) ram[i] <= 8'h5A;
    if (mon_clr)  for (int i = 0; i < FW; i++) wcnt[i] <= 8'h00;
    if (mem_we) begin
      wr_total <= wr_total + 1;
      if (int'(mem_addr) < FW) begin
        ram[mem_addr[12:0]]  <= mem_wdata;
        wcnt[mem_addr[12:0]] <= wcnt[mem_addr[12:0]] + 8'd1;
      end
    end
    rdata_q <= (int'(mem_addr) < FW) ? ram[mem_addr[12:0]] : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_we"},    32'(mem_we), 32'h0);
    check({tag, "_ack"},   32'(draw_wr_ack), 32'h0);
    check({tag, "_busy"},  32'(clear_busy), 32'h0);
    check({tag, "_done"},  32'(clear_done), 32'h0);
    check({tag, "_valid"}, 32'(disp_rd_valid), 32'h0);
    check({tag, "_rdata"}, 32'(disp_rd_data), 32'h0);
  endtask

  task automatic scan_ram(input string tag, input logic [7:0] color);
    int bad = 0;
    for (int i = 0; i < FW; i++)
      if (ram[i] !== color || wcnt[i] !== 8'd1) bad++;
    check(tag, 32'(bad), 32'h0);
  endtask

  initial begin
    int base;
    int n;
    int busy_cycles, rd_in_busy, done_cnt, ack_cnt, ack_in_busy, ack_before_done;

    reset = 1'b1; mon_fill = 1'b0; mon_clr = 1'b0;
    disp_rd_req = 1'b0; disp_rd_addr = '0;
    draw_wr_req = 1'b0; draw_wr_addr = '0; draw_wr_data = '0;
    clear_start = 1'b0; clear_color = '0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0; mon_fill = 1'b1; mon_clr = 1'b1;
    tick();
    mon_fill = 1'b0; mon_clr = 1'b0;

    // Basic read: address at t+1, data at t+2
    disp_rd_req = 1'b1; disp_rd_addr = 19'h00010;
    tick();
    disp_rd_req = 1'b0;
    check("rd1_addr", 32'(mem_addr), 32'h10);
    check("rd1_we", 32'(mem_we), 32'h0);
    check("rd1_valid_early", 32'(disp_rd_valid), 32'h0);
    tick();
    check("rd1_valid", 32'(disp_rd_valid), 32'h1);
    check("rd1_data", 32'(disp_rd_data), 32'h5A);

    // Read beats a held draw; draw lands one cycle later and only once
    base = wr_total;
    draw_wr_req = 1'b1; draw_wr_addr = 19'h01234; draw_wr_data = 8'h3C;
    disp_rd_req = 1'b1; disp_rd_addr = 19'h00020;
    tick();
    disp_rd_req = 1'b0;
    check("pri_ack0", 32'(draw_wr_ack), 32'h0);
    check("pri_we0", 32'(mem_we), 32'h0);
    check("pri_addr_rd", 32'(mem_addr), 32'h20);
    tick();
    check("wr_we", 32'(mem_we), 32'h1);
    check("wr_addr", 32'(mem_addr), 32'h1234);
    check("wr_data", 32'(mem_wdata), 32'h3C);
    check("wr_ack", 32'(draw_wr_ack), 32'h1);
    check("rd2_valid", 32'(disp_rd_valid), 32'h1);
    check("rd2_data", 32'(disp_rd_data), 32'h5A);
    tick();
    check("wr_no_dup_we", 32'(mem_we), 32'h0);
    check("wr_no_dup_ack", 32'(draw_wr_ack), 32'h0);
    draw_wr_req = 1'b0;
    tick();
    check("wr_count", 32'(wr_total - base), 32'h1);
    check("wr_ram", 32'(ram[13'h1234]), 32'h3C);

    // Out-of-range draw is acked but never written
    draw_wr_req = 1'b1; draw_wr_addr = 19'd307200; draw_wr_data = 8'h99;
    tick();
    check("oobw_ack", 32'(draw_wr_ack), 32'h1);
    check("oobw_we", 32'(mem_we), 32'h0);
    check("oobw_addr_hold", 32'(mem_addr), 32'h1234);
    tick();
    draw_wr_req = 1'b0;
    check("oobw_ack_end", 32'(draw_wr_ack), 32'h0);
    check("oobw_we_end", 32'(mem_we), 32'h0);

    // Out-of-range read leaves the slot to a same-cycle draw; data returns as 0
    disp_rd_req = 1'b1; disp_rd_addr = 19'd400000;
    draw_wr_req = 1'b1; draw_wr_addr = 19'h00100; draw_wr_data = 8'h11;
    tick();
    disp_rd_req = 1'b0;
    check("oobr_draw_ack", 32'(draw_wr_ack), 32'h1);
    check("oobr_draw_we", 32'(mem_we), 32'h1);
    check("oobr_draw_addr", 32'(mem_addr), 32'h100);
    check("oobr_draw_data", 32'(mem_wdata), 32'h11);
    tick();
    draw_wr_req = 1'b0;
    check("oobr_valid", 32'(disp_rd_valid), 32'h1);
    check("oobr_data", 32'(disp_rd_data), 32'h0);
    check("oobr_we", 32'(mem_we), 32'h0);
    tick();

    // Full clear with interleaved reads, a held draw and an ignored second start
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    clear_start = 1'b1; clear_color = 8'h07;
    tick();
    clear_start = 1'b0; clear_color = 8'hFF;
    check("clr_busy_start", 32'(clear_busy), 32'h1);
    draw_wr_req = 1'b1; draw_wr_addr = 19'd307200; draw_wr_data = 8'hAA;
    busy_cycles = 0; rd_in_busy = 0; done_cnt = 0;
    ack_cnt = 0; ack_in_busy = 0; ack_before_done = 0;
    n = 0;
    while (ack_cnt == 0 && n < 3 * FW) begin
      if (clear_busy) busy_cycles++;
      disp_rd_req  = n[0];
      disp_rd_addr = 19'(n % FW);
      clear_start  = (n == 50);
      if (clear_busy && disp_rd_req) rd_in_busy++;
      tick();
      n++;
      if (clear_done) done_cnt++;
      if (draw_wr_ack) begin
        ack_cnt++;
        if (clear_busy) ack_in_busy++;
        if (done_cnt == 0) ack_before_done++;
      end
    end
    disp_rd_req = 1'b0; clear_start = 1'b0;
    tick();
    draw_wr_req = 1'b0;
    tick(); tick();
    check("clr_duration", 32'(busy_cycles), 32'(FW + rd_in_busy));
    check("clr_done_once", 32'(done_cnt), 32'h1);
    check("clr_draw_acked", 32'(ack_cnt), 32'h1);
    check("clr_ack_in_busy", 32'(ack_in_busy), 32'h0);
    check("clr_ack_early", 32'(ack_before_done), 32'h0);
    check("clr_busy_end", 32'(clear_busy), 32'h0);
    scan_ram("clr_ram_07", 8'h07);

    // Reset mid-clear at counter 1000, with a read in flight
    clear_start = 1'b1; clear_color = 8'h22;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (!(mem_we && mem_addr == 19'd999) && n < 2000) begin
      tick();
      n++;
    end
    check("rst_reach_999", 32'(mem_addr), 32'd999);
    disp_rd_req = 1'b1; disp_rd_addr = 19'h00030;
    tick();
    disp_rd_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_mid");
    done_cnt = 0; n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (clear_done || clear_busy || mem_we || disp_rd_valid) n++;
      if (clear_done) done_cnt++;
    end
    check("rst_quiet", 32'(n), 32'h0);
    check("rst_no_done", 32'(done_cnt), 32'h0);

    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    clear_start = 1'b1; clear_color = 8'h33;
    tick();
    clear_start = 1'b0;
    check("re_busy", 32'(clear_busy), 32'h1);
    tick();
    check("re_we", 32'(mem_we), 32'h1);
    check("re_addr0", 32'(mem_addr), 32'h0);
    check("re_data", 32'(mem_wdata), 32'h33);
    tick();
    check("re_addr1", 32'(mem_addr), 32'h1);
    done_cnt = 0; n = 0;
    while (done_cnt == 0 && n < FW + 20) begin
      tick();
      n++;
      if (clear_done) done_cnt++;
    end
    check("re_done", 32'(done_cnt), 32'h1);
    tick(); tick();
    scan_ram("re_ram_33", 8'h33);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
